// File: rtl/npu_tile_scheduler_pkg.sv
// Shared types and tile geometry for the NPU tile scheduler.
// The default tile shape is fixed here and sized into tile_cmd_t.
package pkg_npu_sched;

    localparam int TILE_ROWS  = 16;
    localparam int TILE_COLS  = 16;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DIM_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5
    } sched_state_e;

    // Command view at the default tile geometry.
    typedef struct packed {
        logic [CMD_ADDR_W-1:0]      a_base;
        logic [CMD_ADDR_W-1:0]      w_base;
        logic [CMD_ADDR_W-1:0]      o_base;
        logic [$clog2(TILE_ROWS):0] rows;
        logic [$clog2(TILE_COLS):0] cols;
        logic [CMD_DIM_W-1:0]       k;
    } tile_cmd_t;

endpackage

// File: rtl/npu_tile_scheduler_addr_gen.sv
// Remainder counters and base-pointer adders for the output-tile walk.
// All pointer movement is incremental; adds wrap at ADDR_WIDTH.
module npu_tile_addr_gen
    import pkg_npu_sched::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_W      = 16,
    parameter int ARRAY_N    = TILE_ROWS,
    parameter int ARRAY_M    = TILE_COLS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_i,
    input  logic                  step_n_i,
    input  logic                  step_m_i,
    input  logic [DIM_W-1:0]      cfg_m_i,
    input  logic [DIM_W-1:0]      cfg_n_i,
    input  logic [DIM_W-1:0]      cfg_k_i,
    input  logic [ADDR_WIDTH-1:0] a_base_i,
    input  logic [ADDR_WIDTH-1:0] w_base_i,
    input  logic [ADDR_WIDTH-1:0] o_base_i,
    output logic [DIM_W-1:0]      m_rem_o,
    output logic [DIM_W-1:0]      n_rem_o,
    output logic [ADDR_WIDTH-1:0] a_ptr_o,
    output logic [ADDR_WIDTH-1:0] w_ptr_o,
    output logic [ADDR_WIDTH-1:0] o_ptr_o,
    output logic                  last_n_o,
    output logic                  last_m_o
);

    localparam logic [DIM_W-1:0]      STEP_M = DIM_W'(ARRAY_N);
    localparam logic [DIM_W-1:0]      STEP_N = DIM_W'(ARRAY_M);
    localparam logic [ADDR_WIDTH-1:0] O_STEP = ADDR_WIDTH'(ARRAY_N);

    logic [DIM_W-1:0]      m_rem_q, m_rem_d, n_rem_q, n_rem_d;
    logic [ADDR_WIDTH-1:0] a_ptr_q, a_ptr_d, w_ptr_q, w_ptr_d, o_ptr_q, o_ptr_d;
    logic [ADDR_WIDTH-1:0] k_ext;

    assign k_ext = ADDR_WIDTH'(cfg_k_i);

    always_comb begin
        m_rem_d = m_rem_q;
        n_rem_d = n_rem_q;
        a_ptr_d = a_ptr_q;
        w_ptr_d = w_ptr_q;
        o_ptr_d = o_ptr_q;
        if (init_i) begin
            m_rem_d = cfg_m_i;
            n_rem_d = cfg_n_i;
            a_ptr_d = a_base_i;
            w_ptr_d = w_base_i;
            o_ptr_d = o_base_i;
        end else if (step_m_i) begin
            // Wrap to the first column of the next row band.
            m_rem_d = m_rem_q - STEP_M;
            n_rem_d = cfg_n_i;
            w_ptr_d = w_base_i;
            a_ptr_d = a_ptr_q + k_ext;
            o_ptr_d = o_ptr_q + O_STEP;
        end else if (step_n_i) begin
            n_rem_d = n_rem_q - STEP_N;
            w_ptr_d = w_ptr_q + k_ext;
            o_ptr_d = o_ptr_q + O_STEP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_rem_q <= '0;
            n_rem_q <= '0;
            a_ptr_q <= '0;
            w_ptr_q <= '0;
            o_ptr_q <= '0;
        end else begin
            m_rem_q <= m_rem_d;
            n_rem_q <= n_rem_d;
            a_ptr_q <= a_ptr_d;
            w_ptr_q <= w_ptr_d;
            o_ptr_q <= o_ptr_d;
        end
    end

    assign m_rem_o  = m_rem_q;
    assign n_rem_o  = n_rem_q;
    assign a_ptr_o  = a_ptr_q;
    assign w_ptr_o  = w_ptr_q;
    assign o_ptr_o  = o_ptr_q;
    assign last_n_o = (n_rem_q <= STEP_N);
    assign last_m_o = (m_rem_q <= STEP_M);

endmodule

// File: rtl/npu_tile_scheduler.sv
// GEMM tile scheduler: walks output tiles (n inner, m outer), issues one
// command per tile over valid/ready and waits for its completion pulse.
module npu_tile_scheduler
    import pkg_npu_sched::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ARRAY_N    = TILE_ROWS,
    parameter int ARRAY_M    = TILE_COLS,
    parameter int DIM_W      = 16,
    localparam int RW        = $clog2(ARRAY_N) + 1,
    localparam int CW        = $clog2(ARRAY_M) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DIM_W-1:0]      cfg_m_i,
    input  logic [DIM_W-1:0]      cfg_n_i,
    input  logic [DIM_W-1:0]      cfg_k_i,
    input  logic [ADDR_WIDTH-1:0] cfg_a_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_w_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_o_base_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [ADDR_WIDTH-1:0] cmd_a_base_o,
    output logic [ADDR_WIDTH-1:0] cmd_w_base_o,
    output logic [ADDR_WIDTH-1:0] cmd_o_base_o,
    output logic [RW-1:0]         cmd_num_rows_o,
    output logic [CW-1:0]         cmd_num_cols_o,
    output logic [DIM_W-1:0]      cmd_k_o,
    input  logic                  op_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           tile_cnt_o
);

    sched_state_e          state_q, state_d;
    logic                  err_q, err_d;
    logic [15:0]           tile_cnt_q, tile_cnt_d;
    logic [DIM_W-1:0]      cfg_m_q, cfg_m_d, cfg_n_q, cfg_n_d, cfg_k_q, cfg_k_d;
    logic [ADDR_WIDTH-1:0] cfg_a_q, cfg_a_d, cfg_w_q, cfg_w_d, cfg_o_q, cfg_o_d;
    logic                  init, step_n, step_m, last_n, last_m;
    logic [DIM_W-1:0]      m_rem, n_rem;

    npu_tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_W      (DIM_W),
        .ARRAY_N    (ARRAY_N),
        .ARRAY_M    (ARRAY_M)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .init_i   (init),
        .step_n_i (step_n),
        .step_m_i (step_m),
        .cfg_m_i  (cfg_m_q),
        .cfg_n_i  (cfg_n_q),
        .cfg_k_i  (cfg_k_q),
        .a_base_i (cfg_a_q),
        .w_base_i (cfg_w_q),
        .o_base_i (cfg_o_q),
        .m_rem_o  (m_rem),
        .n_rem_o  (n_rem),
        .a_ptr_o  (cmd_a_base_o),
        .w_ptr_o  (cmd_w_base_o),
        .o_ptr_o  (cmd_o_base_o),
        .last_n_o (last_n),
        .last_m_o (last_m)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        tile_cnt_d = tile_cnt_q;
        cfg_m_d    = cfg_m_q;
        cfg_n_d    = cfg_n_q;
        cfg_k_d    = cfg_k_q;
        cfg_a_d    = cfg_a_q;
        cfg_w_d    = cfg_w_q;
        cfg_o_d    = cfg_o_q;
        init       = 1'b0;
        step_n     = 1'b0;
        step_m     = 1'b0;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                state_d    = S_CHECK;
                err_d      = 1'b0;
                tile_cnt_d = '0;
                cfg_m_d    = cfg_m_i;
                cfg_n_d    = cfg_n_i;
                cfg_k_d    = cfg_k_i;
                cfg_a_d    = cfg_a_base_i;
                cfg_w_d    = cfg_w_base_i;
                cfg_o_d    = cfg_o_base_i;
            end
            S_CHECK: begin
                if (cfg_m_q == '0 || cfg_n_q == '0 || cfg_k_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    init    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: if (cmd_ready_i) state_d = S_WAIT;
            S_WAIT: if (op_done_i) begin
                state_d = S_NEXT;
                if (tile_cnt_q != 16'hFFFF) tile_cnt_d = tile_cnt_q + 16'd1;
            end
            S_NEXT: begin
                if (!last_n) begin
                    step_n  = 1'b1;
                    state_d = S_ISSUE;
                end else if (!last_m) begin
                    step_m  = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything in the active states, including a
        // same-cycle handshake or completion.
        if (abort_i && (state_q inside {S_CHECK, S_ISSUE, S_WAIT, S_NEXT})) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            tile_cnt_d = tile_cnt_q;
            init       = 1'b0;
            step_n     = 1'b0;
            step_m     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            tile_cnt_q <= '0;
            cfg_m_q    <= '0;
            cfg_n_q    <= '0;
            cfg_k_q    <= '0;
            cfg_a_q    <= '0;
            cfg_w_q    <= '0;
            cfg_o_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            tile_cnt_q <= tile_cnt_d;
            cfg_m_q    <= cfg_m_d;
            cfg_n_q    <= cfg_n_d;
            cfg_k_q    <= cfg_k_d;
            cfg_a_q    <= cfg_a_d;
            cfg_w_q    <= cfg_w_d;
            cfg_o_q    <= cfg_o_d;
        end
    end

    assign cmd_valid_o    = (state_q == S_ISSUE);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_FIN);
    assign err_o          = err_q;
    assign tile_cnt_o     = tile_cnt_q;
    assign cmd_k_o        = cfg_k_q;
    assign cmd_num_rows_o = (m_rem >= DIM_W'(ARRAY_N)) ? RW'(ARRAY_N) : RW'(m_rem);
    assign cmd_num_cols_o = (n_rem >= DIM_W'(ARRAY_M)) ? CW'(ARRAY_M) : CW'(n_rem);

endmodule
